mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares one single-port synchronous RAM between the instruction-fetch requester and the data requester of the 16-bit CPU. Each requester has its own valid/ready request channel and its own response channel. The block grants at most one memory access per cycle using round-robin, routes read data back to its owner after a fixed latency, and supports a locked read-modify-write sequence for the data side. It sits between the program counter / control unit and a unified RAM.

## Interface
- ADDR_W, 8, address width
- DATA_W, 16, data width
- MEM_LAT, 1, RAM read latency in cycles (legal 1..4)

- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- if_req_valid  in  1  fetch request present
- if_req_addr  in  ADDR_W  fetch address
- if_req_ready  out  1  fetch request accepted this cycle
- if_rsp_valid  out  1  fetch data valid
- if_rsp_data  out  DATA_W  fetched instruction
- d_req_valid  in  1  data request present
- d_req_we  in  1  1 = write, 0 = read
- d_req_lock  in  1  start or hold a locked RMW sequence
- d_req_addr  in  ADDR_W  data address
- d_req_wdata  in  DATA_W  write data
- d_req_ready  out  1  data request accepted this cycle
- d_rsp_valid  out  1  data read result valid (never asserted for writes)
- d_rsp_data  out  DATA_W  read result
- mem_en, mem_we  out  1  RAM access enable / write enable
- mem_addr  out  ADDR_W; mem_wdata  out  DATA_W
- mem_rdata  in  DATA_W  RAM read data, valid MEM_LAT cycles after mem_en
- locked  out  1  arbiter is in LOCKED state

## Operation
- **Accept rule.** A request is accepted when valid && ready. At most one ready is high per cycle. A ready is never high unless its own valid is high.
- **State machine.** States are UNLOCKED and LOCKED; reset state is UNLOCKED.
- **UNLOCKED, single requester.** If only one requester is valid, it wins.
- **UNLOCKED, tie.** If both are valid, the winner is the requester that was not granted last. The last_grant register resets to DATA, so fetch wins the first tie after reset. last_grant updates only on an accept.
- **Entering LOCKED.** An accepted data read with d_req_lock=1 moves the block to LOCKED.
- **LOCKED.** if_req_ready is held at 0; only data is granted. An accepted data write moves the block back to UNLOCKED, in the same edge as the write issues. An accepted data read in LOCKED keeps the lock regardless of d_req_lock.
- **Memory drive.** On accept, mem_en=1, mem_we=d_req_we for data (0 for fetch), and mem_addr / mem_wdata come from the winner. With no accept, mem_en=0 and mem_we=0.
- **Read tagging.** Each accepted read pushes {valid=1, owner} into a MEM_LAT-deep tag pipeline. Writes and idle cycles push valid=0.
- **Response routing.** The pipeline output selects which rsp_valid pulses for one cycle. Both rsp_data outputs carry mem_rdata directly. Responses never collide and are returned in issue order.
- **Address width.** Addresses are not checked or wrapped; they are passed through unchanged.

## Timing
- **Request path.** ready and mem_* are combinational from the valids, the state and last_grant. An accept in cycle T drives the RAM in cycle T.
- **Read latency.** A read accepted in cycle T produces rsp_valid in cycle T+MEM_LAT.
- **Throughput.** One access per cycle. Back-to-back reads from the same or different owners are permitted.
- **Reset values (registered state).** state=UNLOCKED, last_grant=DATA, all tag pipeline entries invalid.
- **Reset values (outputs).** During a reset cycle all ready outputs are forced to 0, mem_en=0, mem_we=0, both rsp_valid=0 and locked=0.
- **Reset mid-operation.** In-flight reads are dropped and no response is produced for them. The lock is released.
- **Simultaneous events.**
  - A data write that unlocks and a pending fetch in the same cycle: only the write is granted; fetch can win next cycle.
  - A valid deasserted before ready: no accept and no state change.

## Structure
- **Package mem_arb_pkg.**
  - owner_t enum: OWN_IF=0, OWN_D=1.
  - arb_state_t enum: UNLOCKED, LOCKED.
  - Tag struct {valid, owner_t}.
- **Sub-module rsp_tag_pipe.** A MEM_LAT-deep shift register of tags, with synchronous clear on reset. It is instantiated once.
- **Top level.** Holds the arbiter FSM, last_grant and the output muxing.

## Test plan
- **Fetch-only reads.** Reset, then fetch-only reads at 0x00..0x03 with MEM_LAT=1 → if_rsp_valid pulses on 4 consecutive cycles with the RAM contents. d_rsp_valid stays 0 throughout.
- **Tie alternation.** Both valid continuously for 6 cycles → grants alternate IF, D, IF, D, IF, D (fetch first after reset).
- **Locked RMW.**
  - Data read at 0x10 with lock=1, then 3 cycles with fetch valid, then data write at 0x10 → if_req_ready=0 and locked=1 until the write is accepted.
  - Fetch is granted in the cycle after the write.
- **Write with no response.** Data write of 0xBEEF at 0x20, then data read at 0x20 → no d_rsp_valid for the write. The read returns 0xBEEF MEM_LAT cycles after its accept.
- **Latency 3.** MEM_LAT=3, interleaved IF/D reads → each response arrives exactly 3 cycles after its accept and on the correct owner port.
- **Mid-flight reset.** Reset asserted 1 cycle after a read accept with MEM_LAT=3 → no rsp_valid for that read. locked=0 and the next tie goes to fetch.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the fetch/data memory port arbiter.
// Owners, FSM states and the read-tag bundle.
package mem_arb_pkg;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_t;

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic   valid;
    owner_t owner;
  } tag_t;

  localparam tag_t TAG_NONE = '{valid: 1'b0, owner: OWN_IF};

endpackage

// File: rtl/rsp_tag_pipe.sv
// Delay line of read tags matching the RAM read latency.
// Output selects which requester sees the returning read data.
module rsp_tag_pipe
  import mem_arb_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic reset,
  input  tag_t push,
  output tag_t pop
);

  tag_t pipe [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        pipe[i] <= TAG_NONE;
      end
    end else begin
      pipe[0] <= push;
      for (int i = 1; i < DEPTH; i++) begin
        pipe[i] <= pipe[i-1];
      end
    end
  end

  assign pop = pipe[DEPTH-1];

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one RAM port between fetch and data,
// with a locked read-modify-write mode for the data side.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 16,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req_valid,
  input  logic [ADDR_W-1:0] if_req_addr,
  output logic              if_req_ready,
  output logic              if_rsp_valid,
  output logic [DATA_W-1:0] if_rsp_data,
  input  logic              d_req_valid,
  input  logic              d_req_we,
  input  logic              d_req_lock,
  input  logic [ADDR_W-1:0] d_req_addr,
  input  logic [DATA_W-1:0] d_req_wdata,
  output logic              d_req_ready,
  output logic              d_rsp_valid,
  output logic [DATA_W-1:0] d_rsp_data,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              locked
);

  arb_state_t state;
  owner_t     last_grant;
  logic       gnt_if;
  logic       gnt_d;
  logic       is_lock;
  logic       tie;
  tag_t       tag_in;
  tag_t       tag_out;

  assign is_lock = (state == LOCKED);
  assign tie     = !is_lock && if_req_valid && d_req_valid;

  always_comb begin
    gnt_if = 1'b0;
    gnt_d  = 1'b0;
    if (!reset) begin
      unique case (1'b1)
        is_lock: gnt_d = d_req_valid;
        tie: begin
          gnt_if = (last_grant == OWN_D);
          gnt_d  = (last_grant == OWN_IF);
        end
        default: begin
          gnt_if = if_req_valid;
          gnt_d  = d_req_valid;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= UNLOCKED;
      last_grant <= OWN_D;
    end else begin
      if (gnt_if) begin
        last_grant <= OWN_IF;
      end else if (gnt_d) begin
        last_grant <= OWN_D;
      end
      if (gnt_d) begin
        unique case (state)
          UNLOCKED: begin
            if (!d_req_we && d_req_lock) begin
              state <= LOCKED;
            end
          end
          LOCKED: begin
            if (d_req_we) begin
              state <= UNLOCKED;
            end
          end
          default: state <= UNLOCKED;
        endcase
      end
    end
  end

  assign if_req_ready = gnt_if;
  assign d_req_ready  = gnt_d;

  assign mem_en    = gnt_if | gnt_d;
  assign mem_we    = gnt_d & d_req_we;
  assign mem_addr  = gnt_d ? d_req_addr : if_req_addr;
  assign mem_wdata = gnt_d ? d_req_wdata : '0;

  // Only reads occupy a slot that will come back with data.
  assign tag_in.valid = mem_en & ~mem_we;
  assign tag_in.owner = gnt_d ? OWN_D : OWN_IF;

  rsp_tag_pipe #(
    .DEPTH(MEM_LAT)
  ) u_tag_pipe (
    .clk  (clk),
    .reset(reset),
    .push (tag_in),
    .pop  (tag_out)
  );

  assign if_rsp_valid = !reset && tag_out.valid && (tag_out.owner == OWN_IF);
  assign d_rsp_valid  = !reset && tag_out.valid && (tag_out.owner == OWN_D);
  assign if_rsp_data  = mem_rdata;
  assign d_rsp_data   = mem_rdata;

  assign locked = !reset && is_lock;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: latency-1 and latency-3
// instances share stimulus, each with its own RAM model.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        ifv;
  logic [7:0]  ifa;
  logic        dv;
  logic        dwe;
  logic        dlk;
  logic [7:0]  da;
  logic [15:0] dwd;

  logic        a_if_rdy, a_if_rv, a_d_rdy, a_d_rv;
  logic [15:0] a_if_rd, a_d_rd;
  logic        a_en, a_we, a_lk;
  logic [7:0]  a_addr;
  logic [15:0] a_wd, a_rdata;

  logic        b_if_rdy, b_if_rv, b_d_rdy, b_d_rv;
  logic [15:0] b_if_rd, b_d_rd;
  logic        b_en, b_we, b_lk;
  logic [7:0]  b_addr;
  logic [15:0] b_wd, b_p0, b_p1, b_rdata;

  logic [15:0] ram1 [256];
  logic [15:0] ram3 [256];

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(8), .DATA_W(16), .MEM_LAT(1)) u1 (
    .clk(clk), .reset(reset),
    .if_req_valid(ifv), .if_req_addr(ifa), .if_req_ready(a_if_rdy),
    .if_rsp_valid(a_if_rv), .if_rsp_data(a_if_rd),
    .d_req_valid(dv), .d_req_we(dwe), .d_req_lock(dlk),
    .d_req_addr(da), .d_req_wdata(dwd), .d_req_ready(a_d_rdy),
    .d_rsp_valid(a_d_rv), .d_rsp_data(a_d_rd),
    .mem_en(a_en), .mem_we(a_we), .mem_addr(a_addr),
    .mem_wdata(a_wd), .mem_rdata(a_rdata), .locked(a_lk)
  );

  mem_port_arbiter #(.ADDR_W(8), .DATA_W(16), .MEM_LAT(3)) u3 (
    .clk(clk), .reset(reset),
    .if_req_valid(ifv), .if_req_addr(ifa), .if_req_ready(b_if_rdy),
    .if_rsp_valid(b_if_rv), .if_rsp_data(b_if_rd),
    .d_req_valid(dv), .d_req_we(dwe), .d_req_lock(dlk),
    .d_req_addr(da), .d_req_wdata(dwd), .d_req_ready(b_d_rdy),
    .d_rsp_valid(b_d_rv), .d_rsp_data(b_d_rd),
    .mem_en(b_en), .mem_we(b_we), .mem_addr(b_addr),
    .mem_wdata(b_wd), .mem_rdata(b_rdata), .locked(b_lk)
  );

  // RAM contents are A000+addr after every reset.
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) ram1[i] <= 16'hA000 + 16'(i);
    end else begin
      if (a_en && a_we) ram1[a_addr] <= a_wd;
      a_rdata <= ram1[a_addr];
    end
  end

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) ram3[i] <= 16'hA000 + 16'(i);
    end else begin
      if (b_en && b_we) ram3[b_addr] <= b_wd;
      b_p0 <= ram3[b_addr];
      b_p1 <= b_p0;
      b_rdata <= b_p1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic drive(input logic iv, input logic [7:0] ia,
                       input logic v, input logic we, input logic lk,
                       input logic [7:0] a, input logic [15:0] wd);
    ifv = iv; ifa = ia; dv = v; dwe = we; dlk = lk; da = a; dwd = wd;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic g(input string tag, input logic eif, input logic ed,
                   input logic elk);
    chk({tag, ".if_rdy"}, 32'(a_if_rdy), 32'(eif));
    chk({tag, ".d_rdy"}, 32'(a_d_rdy), 32'(ed));
    chk({tag, ".mem_en"}, 32'(a_en), 32'(eif | ed));
    chk({tag, ".locked"}, 32'(a_lk), 32'(elk));
    chk({tag, ".if_rdy3"}, 32'(b_if_rdy), 32'(eif));
    chk({tag, ".d_rdy3"}, 32'(b_d_rdy), 32'(ed));
  endtask

  task automatic r1(input string tag, input logic eiv, input logic edv,
                    input logic [15:0] ed);
    chk({tag, ".if_rv1"}, 32'(a_if_rv), 32'(eiv));
    chk({tag, ".d_rv1"}, 32'(a_d_rv), 32'(edv));
    if (eiv) chk({tag, ".if_rd1"}, 32'(a_if_rd), 32'(ed));
    if (edv) chk({tag, ".d_rd1"}, 32'(a_d_rd), 32'(ed));
  endtask

  task automatic r3(input string tag, input logic eiv, input logic edv,
                    input logic [15:0] ed);
    chk({tag, ".if_rv3"}, 32'(b_if_rv), 32'(eiv));
    chk({tag, ".d_rv3"}, 32'(b_d_rv), 32'(edv));
    if (eiv) chk({tag, ".if_rd3"}, 32'(b_if_rd), 32'(ed));
    if (edv) chk({tag, ".d_rd3"}, 32'(b_d_rd), 32'(ed));
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 8'h01, 16'h0000);
    nxt();
    drive(1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 8'h01, 16'h0000);
    g("rst", 0, 0, 0);
    chk("rst.mem_we", 32'(a_we), 32'd0);
    r1("rst", 0, 0, 16'h0);
    r3("rst", 0, 0, 16'h0);
    nxt();
    reset = 1'b0;

    // tie alternation, fetch first after reset
    drive(1'b1, 8'h04, 1'b1, 1'b0, 1'b0, 8'h05, 16'h0000);
    g("t1", 1, 0, 0);
    chk("t1.addr", 32'(a_addr), 32'h04);
    chk("t1.we", 32'(a_we), 32'd0);
    nxt();
    drive(1'b1, 8'h04, 1'b1, 1'b0, 1'b0, 8'h05, 16'h0000);
    g("t2", 0, 1, 0);
    chk("t2.addr", 32'(a_addr), 32'h05);
    r1("t2", 1, 0, 16'hA004);
    nxt();
    drive(1'b1, 8'h04, 1'b1, 1'b0, 1'b0, 8'h05, 16'h0000);
    g("t3", 1, 0, 0);
    r1("t3", 0, 1, 16'hA005);
    r3("t3", 0, 0, 16'h0);
    nxt();
    drive(1'b1, 8'h04, 1'b1, 1'b0, 1'b0, 8'h05, 16'h0000);
    g("t4", 0, 1, 0);
    r1("t4", 1, 0, 16'hA004);
    r3("t4", 1, 0, 16'hA004);
    nxt();
    drive(1'b1, 8'h04, 1'b1, 1'b0, 1'b0, 8'h05, 16'h0000);
    g("t5", 1, 0, 0);
    r1("t5", 0, 1, 16'hA005);
    r3("t5", 0, 1, 16'hA005);
    nxt();
    drive(1'b1, 8'h04, 1'b1, 1'b0, 1'b0, 8'h05, 16'h0000);
    g("t6", 0, 1, 0);
    r1("t6", 1, 0, 16'hA004);
    r3("t6", 1, 0, 16'hA004);
    nxt();
    idle();
    g("t7", 0, 0, 0);
    chk("t7.we", 32'(a_we), 32'd0);
    r1("t7", 0, 1, 16'hA005);
    r3("t7", 0, 1, 16'hA005);
    nxt();
    idle();
    r3("t8", 1, 0, 16'hA004);
    nxt();
    idle();
    r1("t9", 0, 0, 16'h0);
    r3("t9", 0, 1, 16'hA005);
    nxt();

    // fetch-only reads 0x00..0x03
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 8'(i), 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
      g($sformatf("f%0d", i), 1, 0, 0);
      chk($sformatf("f%0d.addr", i), 32'(a_addr), 32'(i));
      if (i > 0) r1($sformatf("f%0d", i), 1, 0, 16'hA000 + 16'(i - 1));
      else r1("f0", 0, 0, 16'h0);
      if (i == 3) r3("f3", 1, 0, 16'hA000);
      nxt();
    end
    idle();
    r1("f4", 1, 0, 16'hA003);
    r3("f4", 1, 0, 16'hA001);
    nxt();
    idle();
    r1("f5", 0, 0, 16'h0);
    r3("f5", 1, 0, 16'hA002);
    nxt();
    idle();
    r3("f6", 1, 0, 16'hA003);
    nxt();

    // locked RMW; last grant was fetch so data wins the tie
    drive(1'b1, 8'h06, 1'b1, 1'b0, 1'b1, 8'h10, 16'h0000);
    g("k1", 0, 1, 0);
    chk("k1.addr", 32'(a_addr), 32'h10);
    nxt();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 8'h06, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
      g($sformatf("k%0d", i + 2), 0, 0, 1);
      if (i == 0) r1("k2", 0, 1, 16'hA010);
      if (i == 2) r3("k4", 0, 1, 16'hA010);
      nxt();
    end
    drive(1'b1, 8'h06, 1'b1, 1'b1, 1'b0, 8'h10, 16'h1234);
    g("k5", 0, 1, 1);
    chk("k5.we", 32'(a_we), 32'd1);
    chk("k5.wdata", 32'(a_wd), 32'h1234);
    nxt();
    drive(1'b1, 8'h06, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
    g("k6", 1, 0, 0);
    r1("k6", 0, 0, 16'h0);
    nxt();
    idle();
    r1("k7", 1, 0, 16'hA006);
    nxt();
    idle();
    r3("k8", 0, 0, 16'h0);
    nxt();
    idle();
    r3("k9", 1, 0, 16'hA006);
    nxt();

    // write produces no response; read-back sees it
    drive(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h20, 16'hBEEF);
    g("w1", 0, 1, 0);
    chk("w1.we", 32'(a_we), 32'd1);
    nxt();
    drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h20, 16'h0000);
    g("w2", 0, 1, 0);
    r1("w2", 0, 0, 16'h0);
    nxt();
    idle();
    r1("w3", 0, 1, 16'hBEEF);
    nxt();
    idle();
    r3("w4", 0, 0, 16'h0);
    nxt();
    idle();
    r3("w5", 0, 1, 16'hBEEF);
    nxt();

    // reset one cycle after a locked read accept
    drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h30, 16'h0000);
    g("m1", 0, 1, 0);
    nxt();
    reset = 1'b1;
    drive(1'b1, 8'h08, 1'b1, 1'b0, 1'b0, 8'h31, 16'h0000);
    g("m2", 0, 0, 0);
    r1("m2", 0, 0, 16'h0);
    r3("m2", 0, 0, 16'h0);
    nxt();
    reset = 1'b0;
    idle();
    g("m3", 0, 0, 0);
    r3("m3", 0, 0, 16'h0);
    nxt();
    drive(1'b1, 8'h07, 1'b1, 1'b0, 1'b0, 8'h31, 16'h0000);
    g("m4", 1, 0, 0);
    r3("m4", 0, 0, 16'h0);
    nxt();
    idle();
    r1("m5", 1, 0, 16'hA007);
    nxt();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
